// File: rtl/ram4k_req_ctrl.sv
// ram4k_req_ctrl: request/response front end for a 4K x 8 banked RAM.
// Requests are registered onto the RAM port; reads are captured two cycles
// later into a small in-order response FIFO. Credit accounting on req_ready
// guarantees the FIFO can never overflow or underflow.
module ram4k_req_ctrl #(
  parameter int RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_CAP   = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic               ram_we_q,   ram_we_d;
  logic [11:0]        ram_addr_q, ram_addr_d;
  logic [7:0]         ram_din_q,  ram_din_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [7:0]         fifo_q [RSP_DEPTH];
  logic [7:0]         fifo_d [RSP_DEPTH];

  logic               inflight;
  logic [CNT_W-1:0]   occupancy;
  logic               accept;
  logic               push;
  logic               pop;

  // Handshake: a read in flight reserves a FIFO slot, so accept only when one is free.
  always_comb begin
    inflight  = (state_q == RD_ISSUE) || (state_q == RD_CAP);
    occupancy = count_q + CNT_W'(inflight);
    req_ready = (state_q != RD_ISSUE) && (occupancy < CNT_W'(RSP_DEPTH));
    accept    = req_valid && req_ready;
    rsp_valid = (count_q != '0);
    rsp_data  = fifo_q[rd_ptr_q];
    push      = (state_q == RD_CAP);
    pop       = rsp_valid && rsp_ready;
  end

  // Next state of the read sequencer and the registered RAM port.
  always_comb begin
    state_d    = state_q;
    ram_we_d   = accept && req_we;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (accept) begin
      ram_addr_d = req_addr;
      ram_din_d  = req_wdata;
    end
    case (state_q)
      IDLE, RD_CAP: state_d = (accept && !req_we) ? RD_ISSUE : IDLE;
      RD_ISSUE:     state_d = RD_CAP;
      default:      state_d = IDLE;
    endcase
  end

  // Next state of the response FIFO: capture RAM data in RD_CAP, pop on transfer.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = ram_dout;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards any read in flight and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram4k_req_ctrl.sv
// Testbench for ram4k_req_ctrl: banked RAM model, reference memory and
// an in-order scoreboard of expected read responses.
module tb_ram4k_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_data;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  ref_mem [4096];
  logic [7:0]  ram_mem [4096];
  logic [7:0]  bank_q [4];
  logic        exp_ram_we = 1'b0;
  logic        rand_rsp = 1'b0;

  ram4k_req_ctrl #(.RSP_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Four 1K banks with registered read data, bank chosen by the current address.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      bank_q[b] <= ram_mem[{2'(b), ram_addr[9:0]}];
    end
    if (ram_we) ram_mem[ram_addr] = ram_din;
  end
  assign ram_dout = bank_q[ram_addr[11:10]];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Response monitor: head of FIFO must match scoreboard; ram_we only after a write accept.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("ram_we_track", 32'(ram_we), 32'(exp_ram_we));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          checkOutput("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
          if (rsp_ready) exp_q.delete(0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    exp_ram_we = 1'b0;
    #1;
    if (rand_rsp) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic we, input logic [11:0] addr, input logic [7:0] data);
    bit took;
    bit accepted = 0;
    int waited = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      took = req_ready;
      @(posedge clk);
      exp_ram_we = took && we;
      if (took) begin
        if (we) ref_mem[addr] = data;
        else    exp_q.push_back(ref_mem[addr]);
        accepted = 1;
      end else begin
        waited++;
      end
      #1;
      if (rand_rsp) rsp_ready = 1'($urandom_range(0, 1));
    end
    req_valid = 1'b0;
    checkOutput("accept", 32'(accepted), 32'd1);
  endtask

  task automatic drain();
    int waited = 0;
    rand_rsp  = 1'b0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && waited < 100) begin
      tick();
      waited++;
    end
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = 8'(i * 7 + (i >> 5));
      ref_mem[i] = 8'(i * 7 + (i >> 5));
    end

    // Reset values while held in reset.
    #2;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_ram_din", 32'(ram_din), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
    tick();

    // Write then read same address; check read latency.
    applyStimulus(1'b1, 12'h000, 8'hA5);
    checkOutput("wr_ram_we", 32'(ram_we), 32'd1);
    checkOutput("wr_ram_addr", 32'(ram_addr), 32'h000);
    checkOutput("wr_ram_din", 32'(ram_din), 32'hA5);
    tick();
    checkOutput("wr_ram_we_pulse", 32'(ram_we), 32'd0);
    applyStimulus(1'b0, 12'h000, 8'h00);
    checkOutput("rd_issue_ready", 32'(req_ready), 32'd0);
    checkOutput("rd_issue_valid", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("rd_cap_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rd_cap_ready", 32'(req_ready), 32'd1);
    tick();
    checkOutput("rd_lat_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rd_lat_data", 32'(rsp_data), 32'hA5);
    drain();

    // One write per bank at the same offset, then reads in order.
    applyStimulus(1'b1, 12'h005, 8'h11);
    applyStimulus(1'b1, 12'h405, 8'h22);
    applyStimulus(1'b1, 12'h805, 8'h33);
    applyStimulus(1'b1, 12'hC05, 8'h44);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, {2'(k), 10'h005}, 8'h00);
      checkOutput("bank_rd_ready_low", 32'(req_ready), 32'd0);
      tick();
      checkOutput("bank_rd_ready_high", 32'(req_ready), 32'd1);
    end
    drain();

    // Backpressure: third read held until a response is popped.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 12'h005, 8'h00);
    applyStimulus(1'b0, 12'h405, 8'h00);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 12'h805;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_ready", 32'(req_ready), 32'd0);
      checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_data", 32'(rsp_data), 32'h11);
      tick();
    end
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 12'h805, 8'h00);
    drain();

    // Read-after-write on the next cycle at the top of bank 0.
    applyStimulus(1'b1, 12'h3FF, 8'h7E);
    applyStimulus(1'b0, 12'h3FF, 8'h00);
    tick();
    tick();
    checkOutput("raw_data", 32'(rsp_data), 32'h7E);
    drain();

    // Reset during RD_CAP discards the read.
    applyStimulus(1'b0, 12'h405, 8'h00);
    tick();
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("midrst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_addr", 32'(ram_addr), 32'd0);
    tick();
    rst = 1'b0;
    checkOutput("midrst_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(1'b0, 12'h000, 8'h00);
    tick();
    tick();
    checkOutput("midrst_next_rd", 32'(rsp_data), 32'hA5);
    drain();

    // Random mixed traffic against the reference memory.
    rand_rsp = 1'b1;
    for (int n = 0; n < 200; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram4k_req_ctrl.md
RAM4K_REQ_CTRL -- requirements
Module: ram4k_req_ctrl

Interface
REQ-001 Parameter: RSP_DEPTH, 2, response buffer entries; power of two, >= 2.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  upstream request present.
REQ-005 req_ready  out  1  block accepts request this cycle.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  12  byte address; [11:10] = bank, [9:0] = offset.
REQ-008 req_wdata  in  8  write data.
REQ-009 rsp_valid  out  1  read data available.
REQ-010 rsp_ready  in  1  downstream consumes response.
REQ-011 rsp_data  out  8  read data, request order.
REQ-012 ram_we  out  1  write enable to 4K x 8 RAM.
REQ-013 ram_addr  out  12  address to RAM.
REQ-014 ram_din  out  8  write data to RAM.
REQ-015 ram_dout  in  8  RAM read data; registered 1 cycle after address; bank select is combinational on current ram_addr[11:10].

Function
REQ-016 Request accepted on a rising edge where req_valid and req_ready are both 1; response transferred on a rising edge where rsp_valid and rsp_ready are both 1.
REQ-017 ram_we, ram_addr and ram_din SHALL be registers, loaded only on request accept; ram_addr/ram_din hold their value until the next accept.
REQ-018 ram_we = 1 for exactly the one cycle after a write accept, else 0.
REQ-019 FSM states: IDLE, RD_ISSUE, RD_CAP.
REQ-020 Transitions: IDLE/RD_CAP -> RD_ISSUE on read accept; IDLE/RD_CAP -> IDLE on write accept or no accept; RD_ISSUE -> RD_CAP unconditionally.
REQ-021 RD_ISSUE: RAM latches read; req_ready = 0, so ram_addr stays stable through RD_CAP for the bank mux.
REQ-022 RD_CAP: ram_dout is pushed into the response buffer at the end of this cycle; a new accept in this cycle is legal.
REQ-023 Read latency: accept on edge N -> rsp_valid = 1 from cycle N+3 if buffer was empty; max read throughput 1 per 2 cycles; writes back-to-back, 1 per cycle.
REQ-024 inflight = 1 in RD_ISSUE or RD_CAP, else 0; req_ready = (state != RD_ISSUE) and (count + inflight < RSP_DEPTH), independent of req_we and req_valid.
REQ-025 Response buffer: FIFO of RSP_DEPTH x 8, count width log2(RSP_DEPTH)+1; pointers wrap modulo RSP_DEPTH.
REQ-026 rsp_valid = (count != 0); rsp_data = head entry, held stable while rsp_valid=1 and rsp_ready=0.
REQ-027 Simultaneous push and pop: count unchanged, both pointers advance; pop on empty and push when full SHALL never occur (guaranteed by REQ-024).
REQ-028 Read after write to same address, write accepted cycle N, read accepted N+1: read returns new data.
REQ-029 No data-dependent behaviour; bank field is passed through unmodified.

Reset
REQ-030 On rst=1, immediately: state IDLE, ram_we 0, ram_addr 0, ram_din 0, FIFO empty (pointers and count 0), rsp_valid 0, rsp_data 0.
REQ-031 rst asserted mid-read (RD_ISSUE or RD_CAP) discards the read; no response is ever produced for it.
REQ-032 After rst deasserts, req_ready = 1 in the first cycle.

Verification
REQ-033 Write 0xA5 @0x000, then read @0x000 -> ram_we 1 for one cycle, rsp_data 0xA5 three cycles after read accept.
REQ-034 Writes 0x11@0x005, 0x22@0x405, 0x33@0x805, 0x44@0xC05, then reads in the same order -> responses 0x11,0x22,0x33,0x44 in order; req_ready low exactly one cycle after each read accept.
REQ-035 rsp_ready=0, RSP_DEPTH=2, issue 3 reads -> third held (req_ready 0) until one pop; rsp_data stable while stalled; no data lost.
REQ-036 Write 0x7E @0x3FF accepted, read @0x3FF accepted next cycle -> response 0x7E.
REQ-037 rst pulse in RD_CAP -> rsp_valid 0, no response after reset; next read returns correct data.
REQ-038 Random mixed traffic vs reference memory model, random rsp_ready -> all responses match and are in order; ram_we never asserted without a write accept.
